// File: rtl/stopwatch_pkg.sv
// Shared constants, state encoding and helpers for the MM:SS stopwatch.
package stopwatch_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned NUM_DIG = 4;

    // Digit positions; bit i of the blank mask drives an[i]
    localparam int unsigned DIG_SEC_ONES = 0;
    localparam int unsigned DIG_SEC_TENS = 1;
    localparam int unsigned DIG_MIN_ONES = 2;
    localparam int unsigned DIG_MIN_TENS = 3;

    localparam int unsigned MIN_MAX_DEF = 59;
    localparam int unsigned SEC_MAX_DEF = 59;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    // Mask covering the two digits of the field being adjusted
    function automatic logic [NUM_DIG-1:0] field_mask(input logic sel);
        logic [NUM_DIG-1:0] m;
        m = '0;
        if (sel) begin
            m[DIG_SEC_ONES] = 1'b1;
            m[DIG_SEC_TENS] = 1'b1;
        end else begin
            m[DIG_MIN_ONES] = 1'b1;
            m[DIG_MIN_TENS] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Strobe/control inputs and display outputs of the stopwatch controller.
import stopwatch_pkg::*;

interface stopwatch_ctrl_if;
    logic               tick_1hz;
    logic               tick_2hz;
    logic               tick_blink;
    logic               pause_lvl;
    logic               sel;
    logic               adj;
    logic [BCD_W-1:0]   min_tens;
    logic [BCD_W-1:0]   min_ones;
    logic [BCD_W-1:0]   sec_tens;
    logic [BCD_W-1:0]   sec_ones;
    logic [NUM_DIG-1:0] blank_mask;
    logic               running;

    // Strobe source / display consumer side
    modport master (
        output tick_1hz, tick_2hz, tick_blink, pause_lvl, sel, adj,
        input  min_tens, min_ones, sec_tens, sec_ones, blank_mask, running
    );

    // Controller side
    modport slave (
        input  tick_1hz, tick_2hz, tick_blink, pause_lvl, sel, adj,
        output min_tens, min_ones, sec_tens, sec_ones, blank_mask, running
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MAX back to 00, with carry out on wrap.
import stopwatch_pkg::*;

module bcd_mod_counter #(
    parameter int unsigned MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry
);
    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX % 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

    logic at_max;

    assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign carry  = inc & at_max;

    // BCD increment: ones roll 9->0 into tens, whole value wraps at MAX
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == NINE) begin
                ones <= '0;
                tens <= tens + BCD_W'(1);
            end else begin
                ones <= ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause sequencing, normal/adjust counting, blink mask.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
    parameter int unsigned MIN_MAX       = MIN_MAX_DEF,
    parameter int unsigned SEC_MAX       = SEC_MAX_DEF,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    stopwatch_ctrl_if.slave bus
);
    localparam state_t RESET_STATE = START_RUNNING ? ST_RUN : ST_PAUSED;

    state_t state;
    logic   pause_q;
    logic   blink_phase;
    logic   pause_edge_c;
    logic   is_run_c;
    logic   sec_inc_c;
    logic   min_inc_c;
    logic   sec_carry;
    logic   blink_next_c;

    assign pause_edge_c = bus.pause_lvl & ~pause_q;
    assign is_run_c     = (state == ST_RUN);

    // Normal mode counts on tick_1hz with carry; adjust mode bumps only the selected field
    assign sec_inc_c = is_run_c & ((~bus.adj & bus.tick_1hz) | (bus.adj & bus.sel & bus.tick_2hz));
    assign min_inc_c = is_run_c & ((~bus.adj & sec_carry) | (bus.adj & ~bus.sel & bus.tick_2hz));

    assign blink_next_c = bus.adj & (blink_phase ^ bus.tick_blink);

    // Run/pause FSM toggled by a rising edge of the pause level
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RESET_STATE;
            bus.running <= START_RUNNING;
            pause_q     <= 1'b0;
        end else begin
            pause_q <= bus.pause_lvl;
            if (pause_edge_c) begin
                state       <= (state == ST_RUN) ? ST_PAUSED : ST_RUN;
                bus.running <= (state == ST_PAUSED);
            end
        end
    end

    // Blink phase runs only in adjust mode; mask blanks the field being adjusted
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_phase    <= 1'b0;
            bus.blank_mask <= '0;
        end else begin
            blink_phase    <= blink_next_c;
            bus.blank_mask <= blink_next_c ? field_mask(bus.sel) : '0;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc_c),
        .clr   (1'b0),
        .tens  (bus.sec_tens),
        .ones  (bus.sec_ones),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc_c),
        .clr   (1'b0),
        .tens  (bus.min_tens),
        .ones  (bus.min_ones),
        .carry ()
    );

endmodule
